// File: rtl/am_audio_out_if.sv
// Sample/audio bus of the AM audio back end.
// Envelope samples come in, the audio word, its clip flag and the PWM pin go out.
interface am_audio_out_if #(
   parameter int INPUT_WIDTH = 12
);
   logic                   sample_valid;
   logic [INPUT_WIDTH-1:0] amdemod_in;
   logic [2:0]             gain;
   logic [INPUT_WIDTH-1:0] audio_out;
   logic                   audio_valid;
   logic                   clip;
   logic                   pwm_out;

   // Valid-only strobes with no ready: the source pulses sample_valid for one cycle
   // per sample (back-to-back allowed) and the stage always accepts it. audio_valid
   // pulses once per accepted sample, in order. audio_out and clip hold between pulses.
   modport master (
      output sample_valid, amdemod_in, gain,
      input  audio_out, audio_valid, clip, pwm_out
   );
   modport slave (
      input  sample_valid, amdemod_in, gain,
      output audio_out, audio_valid, clip, pwm_out
   );
endinterface

// File: rtl/am_audio_out.sv
// AM audio back end: leaky-integrator DC removal, power-of-two gain with saturation,
// an offset-binary audio word, and a free-running PWM output for the RC-filtered pin.
module am_audio_out #(
   parameter int INPUT_WIDTH = 12,
   parameter int DC_SHIFT    = 10,
   parameter int PWM_WIDTH   = 8
) (
   input logic           clk,
   input logic           arst,
   am_audio_out_if.slave bus
);
   localparam int W  = INPUT_WIDTH;
   localparam int AW = INPUT_WIDTH + DC_SHIFT;
   localparam int GW = INPUT_WIDTH + 8;
   localparam logic signed [GW-1:0] SAT_MAX = GW'((2 ** (W - 1)) - 1);
   localparam logic signed [GW-1:0] SAT_MIN = -SAT_MAX - GW'(1);

   logic signed [W:0]     x_q, y_q, y_d;
   logic [AW-1:0]         acc_q, acc_d;
   logic [W-1:0]          dc;
   logic                  v1_q, v2_q;
   logic signed [GW-1:0]  g;
   logic [W-1:0]          sat_d, audio_d, audio_q;
   logic                  clip_d, clip_q, valid_q;
   logic [PWM_WIDTH-1:0]  cnt_q, duty_q;
   logic                  pwm_q;

   // acc holds the DC level scaled by 2^DC_SHIFT; x is never negative so acc stays >= 0
   always_comb begin
      dc    = acc_q[AW-1:DC_SHIFT];
      y_d   = x_q - $signed({1'b0, dc});
      acc_d = acc_q + AW'(x_q[W-1:0]) - AW'(dc);
   end

   always_comb begin
      g = $signed({{(GW - W - 1){y_q[W]}}, y_q}) <<< bus.gain;
      if (g > SAT_MAX) begin
         sat_d  = SAT_MAX[W-1:0];
         clip_d = 1'b1;
      end else if (g < SAT_MIN) begin
         sat_d  = SAT_MIN[W-1:0];
         clip_d = 1'b1;
      end else begin
         sat_d  = g[W-1:0];
         clip_d = 1'b0;
      end
      audio_d = {~sat_d[W-1], sat_d[W-2:0]};
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         x_q     <= '0;
         v1_q    <= 1'b0;
         y_q     <= '0;
         acc_q   <= '0;
         v2_q    <= 1'b0;
         audio_q <= {1'b1, {(W - 1){1'b0}}};
         clip_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         v1_q    <= bus.sample_valid;
         if (bus.sample_valid) x_q <= {1'b0, bus.amdemod_in};
         v2_q    <= v1_q;
         if (v1_q) begin
            y_q   <= y_d;
            acc_q <= acc_d;
         end
         valid_q <= v2_q;
         if (v2_q) begin
            audio_q <= audio_d;
            clip_q  <= clip_d;
         end
      end
   end

   // Duty is reloaded only on the last count, so a period is never cut short
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q  <= '0;
         duty_q <= {1'b1, {(PWM_WIDTH - 1){1'b0}}};
         pwm_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_q + PWM_WIDTH'(1);
         if (&cnt_q) duty_q <= audio_q[W-1 -: PWM_WIDTH];
         pwm_q <= (cnt_q < duty_q);
      end
   end

   assign bus.audio_out   = audio_q;
   assign bus.audio_valid = valid_q;
   assign bus.clip        = clip_q;
   assign bus.pwm_out     = pwm_q;
endmodule

// File: tb/tb_am_audio_out.sv
// Bench for am_audio_out: reset, latency, DC convergence, gain/step vectors, PWM extremes,
// mid-stream reset and a randomized run against an arithmetic model of the audio path.
module tb_am_audio_out;
   localparam int W = 12;

   logic clk = 1'b0;
   logic arst;
   always #5 clk = ~clk;

   am_audio_out_if #(.INPUT_WIDTH(W)) bus ();

   am_audio_out #(.INPUT_WIDTH(W), .DC_SHIFT(10), .PWM_WIDTH(8)) dut (
      .clk  (clk),
      .arst (arst),
      .bus  (bus)
   );

   typedef struct {
      int x;
      int gn;
      int exp_audio;
      int exp_clip;
   } vec_t;

   int           tests = 0;
   int           fails = 0;
   int           acc_m = 0;
   logic [W:0]   exp_q[$];
   logic [2:0]   gain_at_edge;
   int           hold_audio = 2048;
   int           hold_clip = 0;
   logic [W:0]   mon_raw;
   int           mon_y, mon_a, mon_c;
   vec_t         vecs[8];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: DC estimate = accumulated level / 1024, output = sample minus estimate
   task automatic model_push(input int x);
      int y;
      y = x - (acc_m / 1024);
      acc_m = acc_m + y;
      exp_q.push_back(y[W:0]);
   endtask

   function automatic void sat_model(input int y, input int gn, output int audio, output int clp);
      int g;
      g = y * (1 << gn);
      if (g > 2047) begin
         audio = 4095; clp = 1;
      end else if (g < -2048) begin
         audio = 0; clp = 1;
      end else begin
         audio = g + 2048; clp = 0;
      end
   endfunction

   task automatic model_clear();
      acc_m = 0;
      exp_q.delete();
      hold_audio = 2048;
      hold_clip = 0;
   endtask

   task automatic drive(input bit v, input int x, input int gn);
      bus.sample_valid = v;
      bus.amdemod_in   = x[W-1:0];
      bus.gain         = gn[2:0];
      if (v) model_push(x);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name, output int audio, output int clp);
      bit ok;
      ok = 0;
      audio = -1;
      clp = -1;
      bus.sample_valid = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (bus.audio_valid) begin
            ok = 1;
            audio = int'(bus.audio_out);
            clp = int'(bus.clip);
         end
         @(posedge clk);
         #1;
      end
      check({name, "_valid_seen"}, int'(ok), 1);
   endtask

   task automatic count_pwm(input int n, output int highs);
      highs = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         highs += int'(bus.pwm_out);
         @(posedge clk);
         #1;
      end
   endtask

   always @(posedge clk) gain_at_edge <= bus.gain;

   // Scoreboard: every audio_valid must match the oldest outstanding sample; otherwise hold
   always @(negedge clk) begin
      if (!arst) begin
         if (bus.audio_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_valid: got audio_valid=1 expected 0 (no sample outstanding)");
            end else begin
               mon_raw = exp_q.pop_front();
               mon_y = $signed(mon_raw);
               sat_model(mon_y, int'(gain_at_edge), mon_a, mon_c);
               hold_audio = mon_a;
               hold_clip = mon_c;
               check("sb_audio_out", int'(bus.audio_out), mon_a);
               check("sb_clip", int'(bus.clip), mon_c);
            end
         end else begin
            check("hold_audio_out", int'(bus.audio_out), hold_audio);
            check("hold_clip", int'(bus.clip), hold_clip);
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a, c, highs;
      vecs[0] = '{2148, 4, 3648, 0};
      vecs[1] = '{1948, 4, 448, 0};
      vecs[2] = '{2148, 5, 4095, 1};
      vecs[3] = '{1948, 5, 0, 1};
      vecs[4] = '{2148, 7, 4095, 1};
      vecs[5] = '{1948, 7, 0, 1};
      vecs[6] = '{2148, 0, 2148, 0};
      vecs[7] = '{1948, 0, 1948, 0};

      arst = 1'b1;
      bus.sample_valid = 1'b0;
      bus.amdemod_in = '0;
      bus.gain = '0;
      model_clear();
      @(posedge clk);
      #1;

      // Reset held for 5 clocks under random inputs
      for (int i = 0; i < 5; i++) begin
         bus.sample_valid = 1'($urandom_range(0, 1));
         bus.amdemod_in = W'($urandom_range(0, 4095));
         bus.gain = 3'($urandom_range(0, 7));
         @(negedge clk);
         check("rst_audio_out", int'(bus.audio_out), 2048);
         check("rst_audio_valid", int'(bus.audio_valid), 0);
         check("rst_clip", int'(bus.clip), 0);
         check("rst_pwm_out", int'(bus.pwm_out), 0);
         @(posedge clk);
         #1;
      end
      bus.sample_valid = 1'b0;
      bus.gain = '0;
      arst = 1'b0;
      count_pwm(256, highs);
      check("pwm_after_reset_p1", highs, 128);
      count_pwm(256, highs);
      check("pwm_after_reset_p2", highs, 128);

      // Latency: strobe driven at relative edge 10, audio_valid only after edge 13
      arst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      arst = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.sample_valid = 1'b1;
      bus.amdemod_in = W'(2048);
      bus.gain = 3'd0;
      model_push(2048);
      @(posedge clk);
      #1;
      bus.sample_valid = 1'b0;
      for (int e = 11; e <= 16; e++) begin
         @(negedge clk);
         check($sformatf("lat_valid_edge%0d", e), int'(bus.audio_valid), (e == 13) ? 1 : 0);
         if (e == 13) begin
            check("lat_audio_out", int'(bus.audio_out), 4095);
            check("lat_clip", int'(bus.clip), 1);
         end
         @(posedge clk);
         #1;
      end

      // DC convergence on a constant midscale envelope
      for (int i = 0; i < 20000; i++) drive(1'b1, 2048, 0);
      repeat (5) drive(1'b0, 2048, 0);
      tests++;
      if (bus.audio_out < 12'd2047 || bus.audio_out > 12'd2049) begin
         fails++;
         $display("FAIL conv_audio_out: got %0d expected 2048+/-1", bus.audio_out);
      end
      check("conv_clip", int'(bus.clip), 0);

      // Step vectors from the converged state
      foreach (vecs[i]) begin
         drive(1'b1, vecs[i].x, vecs[i].gn);
         wait_valid($sformatf("vec%0d", i), a, c);
         check($sformatf("vec%0d_audio", i), a, vecs[i].exp_audio);
         check($sformatf("vec%0d_clip", i), c, vecs[i].exp_clip);
      end

      // Gain changed while the sample is already past stage 1 still applies in stage 3
      drive(1'b1, 2148, 0);
      drive(1'b0, 2148, 0);
      bus.gain = 3'd4;
      wait_valid("gain_late", a, c);
      check("gain_late_audio", a, 3648);
      drive(1'b1, 1948, 0);
      wait_valid("gain_restore", a, c);
      check("gain_restore_audio", a, 1948);

      // PWM extremes: full-scale and zero duty
      drive(1'b1, 2148, 5);
      wait_valid("pwm_hi", a, c);
      repeat (300) drive(1'b0, 2148, 5);
      count_pwm(256, highs);
      check("pwm_full_scale", highs, 255);
      drive(1'b1, 1948, 5);
      wait_valid("pwm_lo", a, c);
      repeat (300) drive(1'b0, 1948, 5);
      count_pwm(256, highs);
      check("pwm_zero", highs, 0);

      // Reset one cycle after a strobe drops the sample and restarts the DC estimate
      drive(1'b1, 3000, 0);
      bus.sample_valid = 1'b0;
      arst = 1'b1;
      model_clear();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      arst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("midrst_no_valid", int'(bus.audio_valid), 0);
         @(posedge clk);
         #1;
      end
      drive(1'b1, 2048, 0);
      wait_valid("midrst_first", a, c);
      check("midrst_first_audio", a, 4095);
      check("midrst_first_clip", c, 1);
      drive(1'b1, 2048, 0);
      wait_valid("midrst_second", a, c);
      check("midrst_second_audio", a, 4094);
      check("midrst_second_clip", c, 0);

      // Randomized run: random density, envelope and per-cycle gain
      for (int i = 0; i < 3000; i++)
         drive(1'($urandom_range(0, 9) < 7), int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)));
      repeat (6) drive(1'b0, 0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
